// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/flush controllers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state enum, register-address width, stall-cycle
// constants for branch-operand hazards, the hardwired zero register index,
// and the packed hazard-class vector produced by hazard_match.
package pipe_ctrl_pkg;

    localparam int RA_W          = 5;
    localparam int ALU_BR_STALL  = 1;
    localparam int LOAD_BR_STALL = 2;
    // Down-counter width; must hold max(LOAD_BR_STALL, ALU_BR_STALL) - 1.
    localparam int CNT_W         = 2;
    // Register 0 is hardwired to zero, so writing it never creates a dependency.
    localparam int ZERO_REG      = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One bit per hazard class seen for the instruction in ID.
    typedef struct packed {
        logic h_load;
        logic h_alu_br;
        logic h_mem_br;
    } hz_t;

endpackage

// File: rtl/if_id_hazard_ctrl_hazard_match.sv
// Purpose: classify operand hazards of the ID instruction against EX/MEM producers.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller turns the returned stall need into stalls.
//
// Ports:
//   rs_IF_ID/rt_IF_ID        source fields of the instruction in ID
//   branch_IF_ID/jump_IF_ID  ID instruction is a conditional branch / jump
//   memread_ID_EX, regwrite_ID_EX, rd_ID_EX   EX-stage producer
//   memread_EX_MEM, rd_EX_MEM                 MEM-stage producer
//   hz                       per-class hazard flags
//   need                     stall cycles required (max over classes, 0 if none)
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W          = pipe_ctrl_pkg::RA_W,
    parameter int ALU_BR_STALL  = pipe_ctrl_pkg::ALU_BR_STALL,
    parameter int LOAD_BR_STALL = pipe_ctrl_pkg::LOAD_BR_STALL,
    parameter int CNT_W         = pipe_ctrl_pkg::CNT_W
) (
    input  logic [RA_W-1:0] rs_IF_ID,
    input  logic [RA_W-1:0] rt_IF_ID,
    input  logic            branch_IF_ID,
    input  logic            jump_IF_ID,
    input  logic            memread_ID_EX,
    input  logic            regwrite_ID_EX,
    input  logic [RA_W-1:0] rd_ID_EX,
    input  logic            memread_EX_MEM,
    input  logic [RA_W-1:0] rd_EX_MEM,
    output hz_t             hz,
    output logic [CNT_W:0]  need
);

    localparam int NW = CNT_W + 1;
    localparam logic [RA_W-1:0] ZERO_RA = RA_W'(ZERO_REG);
    localparam logic [NW-1:0]   ONE_N   = NW'(1);
    localparam logic [NW-1:0]   ALU_N   = NW'(ALU_BR_STALL);
    localparam logic [NW-1:0]   LOAD_N  = NW'(LOAD_BR_STALL);

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic [NW-1:0] load_need;

    // A destination of r0 never matches: nothing is actually written.
    assign ex_rs  = (rd_ID_EX  != ZERO_RA) && (rd_ID_EX  == rs_IF_ID);
    assign ex_rt  = (rd_ID_EX  != ZERO_RA) && (rd_ID_EX  == rt_IF_ID);
    assign mem_rs = (rd_EX_MEM != ZERO_RA) && (rd_EX_MEM == rs_IF_ID);
    assign mem_rt = (rd_EX_MEM != ZERO_RA) && (rd_EX_MEM == rt_IF_ID);

    // The rt field of a jump is part of the target, not a source operand.
    assign hz.h_load   = memread_ID_EX & (ex_rs | (ex_rt & ~jump_IF_ID));
    assign hz.h_alu_br = branch_IF_ID & regwrite_ID_EX & ~memread_ID_EX & (ex_rs | ex_rt);
    assign hz.h_mem_br = branch_IF_ID & memread_EX_MEM & (mem_rs | mem_rt);

    // A load feeding a branch must also clear the ID comparator, hence the longer wait.
    assign load_need = branch_IF_ID ? LOAD_N : ONE_N;

    always_comb begin
        need = '0;
        if (hz.h_mem_br && (ONE_N > need)) begin
            need = ONE_N;
        end
        if (hz.h_alu_br && (ALU_N > need)) begin
            need = ALU_N;
        end
        if (hz.h_load && (load_need > need)) begin
            need = load_need;
        end
    end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Purpose: sequence PC / IF/ID hold, IF/ID flush and ID/EX bubble for ID-stage branches.
// Latency: outputs combinational from state and inputs; state advances on rising clk.
// Backpressure: stall holds PC and IF/ID for 1..LOAD_BR_STALL cycles; stall beats flush.
//
// Ports:
//   clk, reset (async, active-low)
//   rs_IF_ID, rt_IF_ID, branch_IF_ID, BEQ_IF_ID, BNE_IF_ID, jump_IF_ID, branch_taken
//   memread_ID_EX, regwrite_ID_EX, rd_ID_EX, memread_EX_MEM, rd_EX_MEM
//   stall         hold PC and IF/ID
//   stall_branch  flush IF/ID on next edge
//   bubble_ID_EX  load a NOP into ID/EX on next edge
//   stall_cycles, flush_count  saturating event counters, present only when
//                              HAZARD_PERF_CNT_EN is defined
module if_id_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W          = pipe_ctrl_pkg::RA_W,
    parameter int ALU_BR_STALL  = pipe_ctrl_pkg::ALU_BR_STALL,
    parameter int LOAD_BR_STALL = pipe_ctrl_pkg::LOAD_BR_STALL,
    parameter int CNT_W         = pipe_ctrl_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] rs_IF_ID,
    input  logic [RA_W-1:0] rt_IF_ID,
    input  logic            branch_IF_ID,
    input  logic            BEQ_IF_ID,
    input  logic            BNE_IF_ID,
    input  logic            jump_IF_ID,
    input  logic            branch_taken,
    input  logic            memread_ID_EX,
    input  logic            regwrite_ID_EX,
    input  logic [RA_W-1:0] rd_ID_EX,
    input  logic            memread_EX_MEM,
    input  logic [RA_W-1:0] rd_EX_MEM,
    output logic            stall,
    output logic            stall_branch,
    output logic            bubble_ID_EX
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    localparam int NW = CNT_W + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    hz_t                hz;
    logic [NW-1:0]      need;
    logic               stall_c, flush_c;

    hazard_match #(
        .RA_W          (RA_W),
        .ALU_BR_STALL  (ALU_BR_STALL),
        .LOAD_BR_STALL (LOAD_BR_STALL),
        .CNT_W         (CNT_W)
    ) u_hazard_match (
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .branch_IF_ID   (branch_IF_ID),
        .jump_IF_ID     (jump_IF_ID),
        .memread_ID_EX  (memread_ID_EX),
        .regwrite_ID_EX (regwrite_ID_EX),
        .rd_ID_EX       (rd_ID_EX),
        .memread_EX_MEM (memread_EX_MEM),
        .rd_EX_MEM      (rd_EX_MEM),
        .hz             (hz),
        .need           (need)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        case (state)
            RUN: begin
                if (need != '0) begin
                    // The first stall cycle is spent here; HOLD covers the rest.
                    stall_c = 1'b1;
                    if (need > NW'(1)) begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_W'(need - NW'(1));
                    end
                end else begin
                    flush_c = jump_IF_ID |
                              (branch_IF_ID & branch_taken & (BEQ_IF_ID | BNE_IF_ID));
                end
            end
            HOLD: begin
                // Comparator result is stale while operands are pending: ignore branch_taken.
                stall_c = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are forced quiet for as long as reset is held, independent of inputs.
    assign stall        = reset & stall_c;
    assign bubble_ID_EX = reset & stall_c;
    assign stall_branch = reset & flush_c;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (stall_branch && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Purpose: directed self-checking bench for if_id_hazard_ctrl with an expectation queue.
// Latency: each step drives inputs after posedge and checks outputs at the following negedge.
// Backpressure: n/a (bench).
module tb_if_id_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs_IF_ID, rt_IF_ID, rd_ID_EX, rd_EX_MEM;
    logic       branch_IF_ID, BEQ_IF_ID, BNE_IF_ID, jump_IF_ID, branch_taken;
    logic       memread_ID_EX, regwrite_ID_EX, memread_EX_MEM;
    logic       stall, stall_branch, bubble_ID_EX;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    if_id_hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .branch_IF_ID   (branch_IF_ID),
        .BEQ_IF_ID      (BEQ_IF_ID),
        .BNE_IF_ID      (BNE_IF_ID),
        .jump_IF_ID     (jump_IF_ID),
        .branch_taken   (branch_taken),
        .memread_ID_EX  (memread_ID_EX),
        .regwrite_ID_EX (regwrite_ID_EX),
        .rd_ID_EX       (rd_ID_EX),
        .memread_EX_MEM (memread_EX_MEM),
        .rd_EX_MEM      (rd_EX_MEM),
        .stall          (stall),
        .stall_branch   (stall_branch),
        .bubble_ID_EX   (bubble_ID_EX)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    typedef struct packed {
        logic s;
        logic f;
        logic b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic s, input logic f, input logic b);
        exp_t e;
        e.s = s;
        e.f = f;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".stall"},        32'(stall),        32'(e.s));
            cmp({tag, ".stall_branch"}, 32'(stall_branch), 32'(e.f));
            cmp({tag, ".bubble"},       32'(bubble_ID_EX), 32'(e.b));
        end
    endtask

    // Expect outputs for the current cycle, then move to just after the next edge.
    task automatic cycle(input string tag, input logic s, input logic f, input logic b);
        push(s, f, b);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_IF_ID       = '0;
        rt_IF_ID       = '0;
        rd_ID_EX       = '0;
        rd_EX_MEM      = '0;
        branch_IF_ID   = 1'b0;
        BEQ_IF_ID      = 1'b0;
        BNE_IF_ID      = 1'b0;
        jump_IF_ID     = 1'b0;
        branch_taken   = 1'b0;
        memread_ID_EX  = 1'b0;
        regwrite_ID_EX = 1'b0;
        memread_EX_MEM = 1'b0;
    endtask

    // Load in EX feeding BEQ rt in ID: two stall cycles, then the branch resolves not-taken.
    task automatic load_branch_seq(input string tag);
        memread_ID_EX = 1'b1; rd_ID_EX = 5'd9;
        branch_IF_ID  = 1'b1; BEQ_IF_ID = 1'b1; rt_IF_ID = 5'd9;
        cycle({tag, ".run"}, 1'b1, 1'b0, 1'b1);
        memread_ID_EX  = 1'b0;
        memread_EX_MEM = 1'b1; rd_EX_MEM = 5'd9;
        branch_taken   = 1'b1;
        cycle({tag, ".hold"}, 1'b1, 1'b0, 1'b1);
        memread_EX_MEM = 1'b0;
        branch_taken   = 1'b0;
        cycle({tag, ".resolve"}, 1'b0, 1'b0, 1'b0);
        clear_inputs();
    endtask

    task automatic taken_bne_seq(input string tag);
        branch_IF_ID = 1'b1; BNE_IF_ID = 1'b1; branch_taken = 1'b1;
        cycle({tag, ".flush"}, 1'b0, 1'b1, 1'b0);
        clear_inputs();
        cycle({tag, ".after"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: quiet outputs, even with a hazard presented.
        cycle("rst_idle", 1'b0, 1'b0, 1'b0);
        memread_ID_EX = 1'b1; rd_ID_EX = 5'd8; rs_IF_ID = 5'd8;
        cycle("rst_gated", 1'b0, 1'b0, 1'b0);
        clear_inputs();
        reset = 1'b1;
        cycle("idle", 1'b0, 1'b0, 1'b0);

        // 1. Load-use on a non-branch: one stall, then the bubble clears EX.
        memread_ID_EX = 1'b1; rd_ID_EX = 5'd8; rs_IF_ID = 5'd8;
        cycle("t1_stall", 1'b1, 1'b0, 1'b1);
        memread_ID_EX = 1'b0;
        cycle("t1_release", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // 2. Load-to-branch: RUN -> HOLD -> RUN with no flush.
        load_branch_seq("t2");

        // 3. Taken BNE without hazards.
        taken_bne_seq("t3");

        // 4. Zero-register producers never stall; jumps flush once; jump rt is not a source.
        memread_ID_EX  = 1'b1; rd_ID_EX  = 5'd0; rs_IF_ID = 5'd0;
        memread_EX_MEM = 1'b1; rd_EX_MEM = 5'd0;
        branch_IF_ID   = 1'b1; BEQ_IF_ID = 1'b1;
        cycle("t4_zero", 1'b0, 1'b0, 1'b0);
        clear_inputs();
        jump_IF_ID = 1'b1;
        cycle("t4_jump", 1'b0, 1'b1, 1'b0);
        memread_ID_EX = 1'b1; rd_ID_EX = 5'd7; rt_IF_ID = 5'd7;
        cycle("t4_jump_rt", 1'b0, 1'b1, 1'b0);
        clear_inputs();
        cycle("t4_after", 1'b0, 1'b0, 1'b0);

        // 5a. ALU result feeding a taken branch: stall wins, flush follows once resolved.
        regwrite_ID_EX = 1'b1; rd_ID_EX = 5'd5; rs_IF_ID = 5'd5;
        branch_IF_ID   = 1'b1; BEQ_IF_ID = 1'b1; branch_taken = 1'b1;
        cycle("t5_alu_br", 1'b1, 1'b0, 1'b1);
        regwrite_ID_EX = 1'b0;
        cycle("t5_taken", 1'b0, 1'b1, 1'b0);
        clear_inputs();

        // 5b. Load in MEM feeding a branch: a single stall.
        memread_EX_MEM = 1'b1; rd_EX_MEM = 5'd3;
        branch_IF_ID   = 1'b1; BNE_IF_ID = 1'b1; rt_IF_ID = 5'd3; branch_taken = 1'b1;
        cycle("t5_mem_br", 1'b1, 1'b0, 1'b1);
        memread_EX_MEM = 1'b0; branch_taken = 1'b0;
        cycle("t5_mem_done", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // 5c. Reset asserted during the HOLD cycle aborts the stall immediately.
        memread_ID_EX = 1'b1; rd_ID_EX = 5'd9;
        branch_IF_ID  = 1'b1; BEQ_IF_ID = 1'b1; rt_IF_ID = 5'd9;
        cycle("t5_enter_hold", 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        push(1'b0, 1'b0, 1'b0);
        check_now("t5_rst_async");
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cmp("t5_state_run", 32'(dut.state), 32'(RUN));
        cycle("t5_post_rst", 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        // 6. Counters after a fresh reset: scenario 2 then scenario 3.
        reset = 1'b0;
        @(posedge clk);
        #1;
        cmp("t6_rst_stall_cycles", stall_cycles, 32'd0);
        cmp("t6_rst_flush_count",  flush_count,  32'd0);
        reset = 1'b1;
        load_branch_seq("t6a");
        taken_bne_seq("t6b");
        cmp("t6_stall_cycles", stall_cycles, 32'd2);
        cmp("t6_flush_count",  flush_count,  32'd1);
`endif

        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
